// File: rtl/rat_ckpt_ctrl.sv
// RAT checkpoint scheduler: circular allocation of shadow pages per in-flight branch,
// in-order retirement on correct resolve, squash of mispredicted and younger pages.
module rat_ckpt_ctrl #(
  parameter int PAGES  = 8,
  parameter int PAGE_W = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              br_dispatch,
  output logic              br_ready,
  output logic [PAGE_W-1:0] br_tag,
  input  logic              resolve_valid,
  input  logic [PAGE_W-1:0] resolve_tag,
  input  logic              resolve_mispredict,
  output logic              save_state,
  output logic [PAGE_W-1:0] save_page,
  output logic              restore_state,
  output logic [PAGE_W-1:0] restore_page,
  output logic              flush,
  output logic [PAGE_W:0]   used_count
);

  localparam logic [PAGE_W:0] FULL = PAGES[PAGE_W:0];

  logic [PAGE_W-1:0] r_head;
  logic [PAGE_W-1:0] r_tail;
  logic [PAGE_W:0]   r_count;
  logic [PAGES-1:0]  r_valid;
  logic [PAGES-1:0]  r_done;
  logic              r_save_state;
  logic [PAGE_W-1:0] r_save_page;
  logic              r_restore_state;
  logic [PAGE_W-1:0] r_restore_page;

  logic              w_tag_live;
  logic              w_mis;
  logic              w_cres;
  logic              w_ret;
  logic              w_accept;
  logic [PAGE_W-1:0] w_dist;
  logic [PAGE_W:0]   w_nclr;
  logic [PAGES-1:0]  w_kill;

  assign w_tag_live = r_valid[resolve_tag];
  assign w_mis      = resolve_valid & resolve_mispredict & w_tag_live;
  assign w_cres     = resolve_valid & ~resolve_mispredict & w_tag_live;
  assign w_ret      = r_valid[r_head] & (r_done[r_head] | (w_cres & (resolve_tag == r_head)));
  assign w_accept   = br_dispatch & br_ready;

  // Pages kept on a squash are head..T-1; everything from T onward up to the tail goes.
  assign w_dist = resolve_tag - r_head;
  assign w_nclr = r_count - {1'b0, w_dist};

  always_comb begin
    w_kill = '0;
    for (int i = 0; i < PAGES; i++) begin
      if ({1'b0, PAGE_W'(i) - resolve_tag} < w_nclr) begin
        w_kill[i] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_head          <= '0;
      r_tail          <= '0;
      r_count         <= '0;
      r_valid         <= '0;
      r_done          <= '0;
      r_save_state    <= 1'b0;
      r_save_page     <= '0;
      r_restore_state <= 1'b0;
      r_restore_page  <= '0;
    end else begin
      r_save_state    <= w_accept & ~w_mis;
      r_restore_state <= w_mis;
      if (w_accept && !w_mis) begin
        r_save_page <= r_tail;
      end
      if (w_mis) begin
        r_restore_page <= resolve_tag;
      end
      if (w_cres) begin
        r_done[resolve_tag] <= 1'b1;
      end
      if (w_mis) begin
        r_tail <= resolve_tag;
        // A head retiring alongside the squash collapses the window to empty at T.
        if (w_ret) begin
          r_head  <= resolve_tag;
          r_count <= '0;
          r_valid <= '0;
        end else begin
          r_count <= {1'b0, w_dist};
          r_valid <= r_valid & ~w_kill;
        end
      end else begin
        if (w_ret) begin
          r_valid[r_head] <= 1'b0;
          r_head          <= r_head + PAGE_W'(1);
        end
        if (w_accept) begin
          r_valid[r_tail] <= 1'b1;
          r_done[r_tail]  <= 1'b0;
          r_tail          <= r_tail + PAGE_W'(1);
        end
        r_count <= r_count + {{PAGE_W{1'b0}}, w_accept} - {{PAGE_W{1'b0}}, w_ret};
      end
    end
  end

  assign br_ready      = (r_count != FULL) & ~r_restore_state;
  assign br_tag        = r_tail;
  assign save_state    = r_save_state;
  assign save_page     = r_save_page;
  assign restore_state = r_restore_state;
  assign restore_page  = r_restore_page;
  assign flush         = r_restore_state;
  assign used_count    = r_count;

endmodule
